// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources.
// A winner that sends a byte without req_last keeps the transmitter locked until its packet ends.
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int TMO    = 16,
    localparam int OW    = $clog2(NREQ),
    localparam int CW    = $clog2(TMO + 1)
) (
    input  logic                   hwclk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        grant,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   busy,
    output logic                   locked,
    output logic [OW-1:0]          owner,
    output logic                   tx_err,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_grant;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_busy;
    logic                r_locked;
    logic [OW-1:0]       r_owner;
    logic                r_tx_err;
    logic [CW-1:0]       r_cnt;

    state_t              w_state_nxt;
    logic [NREQ-1:0]     w_grant_nxt;
    logic                w_tx_start_nxt;
    logic [DATA_W-1:0]   w_tx_data_nxt;
    logic                w_locked_nxt;
    logic [OW-1:0]       w_owner_nxt;
    logic                w_tx_err_nxt;
    logic [CW-1:0]       w_cnt_nxt;

    logic                w_win_valid;
    logic [OW-1:0]       w_win_idx;
    logic [OW:0]         w_cand;

    // Scan from the farthest candidate down to owner+1 so the nearest requester after owner wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = r_owner;
        w_cand      = '0;
        if (r_locked) begin
            w_win_valid = req[r_owner];
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                w_cand = {1'b0, r_owner} + (OW+1)'(k);
                if (w_cand >= (OW+1)'(NREQ)) begin
                    w_cand = w_cand - (OW+1)'(NREQ);
                end
                if (req[w_cand[OW-1:0]]) begin
                    w_win_valid = 1'b1;
                    w_win_idx   = w_cand[OW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = '0;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_locked_nxt   = r_locked;
        w_owner_nxt    = r_owner;
        w_tx_err_nxt   = 1'b0;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            IDLE: begin
                if (tx_ready && w_win_valid) begin
                    w_state_nxt    = START;
                    w_tx_start_nxt = 1'b1;
                    w_grant_nxt    = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
                    w_tx_data_nxt  = req_data[w_win_idx*DATA_W +: DATA_W];
                    w_owner_nxt    = w_win_idx;
                    w_locked_nxt   = ~req_last[w_win_idx];
                end
            end
            START: begin
                w_state_nxt = WAIT_LOW;
                w_cnt_nxt   = '0;
            end
            WAIT_LOW: begin
                if (!tx_ready) begin
                    w_state_nxt = WAIT_HIGH;
                end else if (r_cnt == CW'(TMO - 1)) begin
                    // Transmitter never took the byte: drop it and release any packet lock.
                    w_state_nxt  = IDLE;
                    w_tx_err_nxt = 1'b1;
                    w_locked_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_owner    <= OW'(NREQ - 1);
            r_tx_err   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_locked   <= w_locked_nxt;
            r_owner    <= w_owner_nxt;
            r_tx_err   <= w_tx_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign grant     = r_grant;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign busy      = r_busy;
    assign locked    = r_locked;
    assign owner     = r_owner;
    assign tx_err    = r_tx_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model driving tx_ready.
// Handshake: tx_start pulses one cycle; the model drops tx_ready for tx_low cycles starting the next cycle.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int TMO    = 16;

    logic                   hwclk = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_last = '0;
    logic [NREQ-1:0]        grant;
    logic                   tx_ready;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic                   busy;
    logic                   locked;
    logic [1:0]             owner;
    logic                   tx_err;
    logic [1:0]             dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic m_ready  = 1'b1;
    int   m_cnt    = 0;
    int   tx_low   = 10;
    logic tx_stuck = 1'b0;
    logic tx_block = 1'b0;
    logic mon_en   = 1'b0;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TMO(TMO)) dut (
        .hwclk(hwclk), .reset(reset), .req(req), .req_data(req_data),
        .req_last(req_last), .grant(grant), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .locked(locked),
        .owner(owner), .tx_err(tx_err), .dbg_state(dbg_state)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) begin
        if (!reset) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
        end else if (tx_start && !tx_stuck) begin
            m_ready <= 1'b0;
            m_cnt   <= tx_low;
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) m_ready <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    assign tx_ready = m_ready & ~tx_block;

    // Grant must be at most one-hot and coincide exactly with tx_start.
    always @(negedge hwclk) begin
        if (mon_en) begin
            n_vec++;
            assert (((grant != '0) === tx_start) && $onehot0(grant)) else begin
                n_err++;
                $error("FAIL grant_pulse observed grant=%b tx_start=%b expected one-hot grant with tx_start", grant, tx_start);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        req_data[i*DATA_W +: DATA_W] = d;
        req_last[i] = l;
    endtask

    task automatic wait_start(input string tag, input int budget, input logic [3:0] eg,
                              input logic [7:0] ed, input logic el, input logic [1:0] eo,
                              output int n);
        n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while (!tx_start && n < budget);
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_data"}, 32'(tx_data), 32'(ed));
        chk({tag, "_locked"}, 32'(locked), 32'(el));
        chk({tag, "_owner"}, 32'(owner), 32'(eo));
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while (busy && n < budget);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd3);
        chk({tag, "_tx_err"}, 32'(tx_err), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int n;

        // Reset values
        reset = 1'b0;
        @(negedge hwclk);
        @(negedge hwclk);
        chk_reset_vals("rst");
        reset  = 1'b1;
        mon_en = 1'b1;

        // 1: single byte, transmitter low for 10 cycles
        tx_low = 10;
        set_req(0, 8'h41, 1'b1);
        req = 4'b0001;
        wait_start("t1", 20, 4'b0001, 8'h41, 1'b0, 2'd0, n);
        chk("t1_latency", 32'(n), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        wait_idle("t1", 40, n);
        chk("t1_busy_cycles", 32'(n), 32'd12);
        chk("t1_hold_data", 32'(tx_data), 32'h41);

        // 2: all four requesting, round-robin from requester 0 after reset
        reset = 1'b0;
        @(negedge hwclk);
        reset  = 1'b1;
        tx_low = 3;
        for (int i = 0; i < 4; i++) set_req(i, 8'h30 + 8'(i), 1'b1);
        req = 4'b1111;
        wait_start("t2_0", 20, 4'b0001, 8'h30, 1'b0, 2'd0, n);
        wait_start("t2_1", 20, 4'b0010, 8'h31, 1'b0, 2'd1, n);
        chk("t2_spacing", 32'(n), 32'd6);
        wait_start("t2_2", 20, 4'b0100, 8'h32, 1'b0, 2'd2, n);
        wait_start("t2_3", 20, 4'b1000, 8'h33, 1'b0, 2'd3, n);
        wait_start("t2_4", 20, 4'b0001, 8'h30, 1'b0, 2'd0, n);
        req = 4'b0000;
        wait_idle("t2", 40, n);

        // 3: requester 1 sends a locked 3-byte packet while 0 and 2 wait
        set_req(0, 8'h50, 1'b1);
        set_req(2, 8'h52, 1'b1);
        set_req(1, 8'hAA, 1'b0);
        req = 4'b0111;
        wait_start("t3_aa", 20, 4'b0010, 8'hAA, 1'b1, 2'd1, n);
        set_req(1, 8'hBB, 1'b0);
        wait_start("t3_bb", 20, 4'b0010, 8'hBB, 1'b1, 2'd1, n);
        set_req(1, 8'hCC, 1'b1);
        wait_start("t3_cc", 20, 4'b0010, 8'hCC, 1'b0, 2'd1, n);
        req = 4'b0101;
        wait_start("t3_r2", 20, 4'b0100, 8'h52, 1'b0, 2'd2, n);
        req = 4'b0001;
        wait_start("t3_r0", 20, 4'b0001, 8'h50, 1'b0, 2'd0, n);
        req = 4'b0000;
        wait_idle("t3", 40, n);

        // 4: transmitter ignores tx_start; timeout clears the lock
        tx_stuck = 1'b1;
        set_req(0, 8'h77, 1'b0);
        req = 4'b0001;
        wait_start("t4", 20, 4'b0001, 8'h77, 1'b1, 2'd0, n);
        req = 4'b0000;
        n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while (!tx_err && n < 40);
        chk("t4_err", 32'(tx_err), 32'd1);
        chk("t4_err_delay", 32'(n), 32'd17);
        chk("t4_locked", 32'(locked), 32'd0);
        chk("t4_state", 32'(dbg_state), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge hwclk);
        chk("t4_err_pulse", 32'(tx_err), 32'd0);
        tx_stuck = 1'b0;
        set_req(1, 8'h12, 1'b1);
        req = 4'b0010;
        wait_start("t4_next", 20, 4'b0010, 8'h12, 1'b0, 2'd1, n);
        req = 4'b0000;
        wait_idle("t4", 40, n);

        // 5: transmitter busy elsewhere holds off arbitration
        tx_block = 1'b1;
        set_req(2, 8'h5A, 1'b1);
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            chk("t5_no_start", 32'(tx_start), 32'd0);
        end
        chk("t5_no_grant", 32'(grant), 32'd0);
        tx_block = 1'b0;
        wait_start("t5", 20, 4'b0100, 8'h5A, 1'b0, 2'd2, n);
        chk("t5_latency", 32'(n), 32'd1);
        req = 4'b0000;
        wait_idle("t5", 40, n);

        // 6: reset in WAIT_HIGH with a lock held by requester 3
        tx_low = 10;
        set_req(3, 8'hC3, 1'b0);
        req = 4'b1000;
        wait_start("t6", 20, 4'b1000, 8'hC3, 1'b1, 2'd3, n);
        set_req(0, 8'h0F, 1'b1);
        req = 4'b1001;
        n = 0;
        do begin
            @(negedge hwclk);
            n++;
        end while (dbg_state != 2'd3 && n < 20);
        chk("t6_wait_high", 32'(dbg_state), 32'd3);
        chk("t6_locked_before", 32'(locked), 32'd1);
        reset = 1'b0;
        @(negedge hwclk);
        chk_reset_vals("t6_rst");
        reset = 1'b1;
        wait_start("t6_prio", 20, 4'b0001, 8'h0F, 1'b0, 2'd0, n);
        chk("t6_latency", 32'(n), 32'd1);
        req = 4'b0000;
        wait_idle("t6", 40, n);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
